// File: rtl/gdm_bram_pkg.sv
// Shared constants and state type for the GDM buffer RAM access controller.
package gdm_bram_pkg;

  localparam int unsigned GDM_AW    = 10;
  localparam int unsigned GDM_DW    = 75;
  localparam int unsigned GDM_DEPTH = 1 << GDM_AW;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } gdm_state_e;

endpackage

// File: rtl/gdm_rr_arb2.sv
// Two-way round-robin arbiter: a lone request is granted at once; on contention the
// port named by the pointer wins, and any grant hands priority to the other port.
module gdm_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    // Port 0 granted -> port 1 next, and vice versa.
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gdm_bram_ctrl.sv
// Access controller for the simple-dual-port GDM buffer RAM: round-robin write port,
// fixed-latency read port, optional zero sweep enabled by GDM_BRAM_CLEAR_EN.
module gdm_bram_ctrl
  import gdm_bram_pkg::*;
#(
  parameter int unsigned AW = GDM_AW,
  parameter int unsigned DW = GDM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0_valid,
  output logic          wr0_ready,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  input  logic          wr1_valid,
  output logic          wr1_ready,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_req_addr,
  output logic          rd_rsp_valid,
  output logic [DW-1:0] rd_rsp_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] bram_addra,
  output logic [DW-1:0] bram_dina,
  output logic          bram_wea,
  output logic [AW-1:0] bram_addrb,
  input  logic [DW-1:0] bram_doutb
);

  logic          run;
  logic [1:0]    wr_valid;
  logic [1:0]    grant;
  logic          wr_fire;
  logic          rsp_valid_q;
  logic          wea_q, wea_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [DW-1:0] dina_q, dina_d;

`ifdef GDM_BRAM_CLEAR_EN
  gdm_state_e    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_done_q, clr_done_d;

  assign run      = (state_q == RUN);
  assign clr_busy = (state_q == CLEAR);
  assign clr_done = clr_done_q;
`else
  logic unused_clr_start;

  assign run              = 1'b1;
  assign clr_busy         = 1'b0;
  assign clr_done         = 1'b0;
  assign unused_clr_start = clr_start;
`endif

  // Requests are masked during a sweep so they stay pending and the pointer holds.
  assign wr_valid = {wr1_valid, wr0_valid} & {2{run}};

  gdm_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (wr_valid),
    .advance_i (wr_fire),
    .grant_o   (grant)
  );

  assign wr_fire      = |grant;
  assign wr0_ready    = grant[0];
  assign wr1_ready    = grant[1];
  assign rd_req_ready = run;

  assign bram_addrb   = rd_req_addr;
  assign rd_rsp_data  = bram_doutb;
  assign rd_rsp_valid = rsp_valid_q;
  assign bram_wea     = wea_q;
  assign bram_addra   = addra_q;
  assign bram_dina    = dina_q;

  always_comb begin
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    if (wr_fire) begin
      wea_d   = 1'b1;
      addra_d = grant[1] ? wr1_addr : wr0_addr;
      dina_d  = grant[1] ? wr1_data : wr0_data;
    end
`ifdef GDM_BRAM_CLEAR_EN
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    if (state_q == CLEAR) begin
      wea_d     = 1'b1;
      addra_d   = clr_cnt_q;
      dina_d    = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) begin
        state_d    = RUN;
        clr_done_d = 1'b1;
      end
    end else if (clr_start) begin
      // A write granted this cycle is registered ahead of the first sweep word.
      state_d = CLEAR;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_valid_q <= 1'b0;
`ifdef GDM_BRAM_CLEAR_EN
      state_q     <= RUN;
      clr_cnt_q   <= '0;
      clr_done_q  <= 1'b0;
`endif
    end else begin
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      rsp_valid_q <= rd_req_valid & run;
`ifdef GDM_BRAM_CLEAR_EN
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_done_q  <= clr_done_d;
`endif
    end
  end

endmodule

// File: tb/tb_gdm_bram_ctrl.sv
// Bench for gdm_bram_ctrl: behavioural RAM + golden-memory model checked every cycle,
// plus directed scenarios with literal expectations (sweep tests under GDM_BRAM_CLEAR_EN).
module tb_gdm_bram_ctrl;
  import gdm_bram_pkg::*;

  localparam int unsigned AW = GDM_AW;
  localparam int unsigned DW = GDM_DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr0_valid = 1'b0, wr1_valid = 1'b0;
  logic          wr0_ready, wr1_ready;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [DW-1:0] wr0_data = '0, wr1_data = '0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr = '0;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          clr_start = 1'b0;
  logic          clr_busy, clr_done;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [DW-1:0] bram_dina, bram_doutb;
  logic          bram_wea;

  int checks = 0;
  int errors = 0;

  gdm_bram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  // RAM: write port updates at the edge, read port registers its address.
  logic [DW-1:0] ram [GDM_DEPTH];
  logic [AW-1:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (bram_wea) ram[bram_addra] <= bram_dina;
    ram_addr_q <= bram_addrb;
  end
  assign bram_doutb = ram[ram_addr_q];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden model: spec-level view of grants, memory contents and sweep progress.
  logic [DW-1:0] golden [GDM_DEPTH];
  int            m_ptr = 0;
  bit            m_busy = 0;
  int            m_cnt = 0;
  bit            exp_wea = 0, exp_done = 0, exp_rsp_valid = 0;
  logic [AW-1:0] exp_addra = '0;
  logic [DW-1:0] exp_dina = '0, exp_rsp_data = '0;

  function automatic logic [1:0] exp_grant();
    if (m_busy) return 2'b00;
    if (wr0_valid && wr1_valid) return (m_ptr == 1) ? 2'b10 : 2'b01;
    return {wr1_valid, wr0_valid};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    bit         rd_acc;
    if (rst) begin
      m_ptr = 0; m_busy = 0; m_cnt = 0;
      exp_wea = 0; exp_done = 0; exp_rsp_valid = 0;
      exp_addra = '0; exp_dina = '0;
    end else begin
      g      = exp_grant();
      rd_acc = rd_req_valid && !m_busy;
      if (exp_wea) golden[exp_addra] = exp_dina;
      exp_rsp_valid = rd_acc;
      if (rd_acc) exp_rsp_data = golden[rd_req_addr];
      exp_wea  = 0;
      exp_done = 0;
      if (g != 2'b00) begin
        exp_wea   = 1;
        exp_addra = g[1] ? wr1_addr : wr0_addr;
        exp_dina  = g[1] ? wr1_data : wr0_data;
        m_ptr     = g[1] ? 0 : 1;
      end
`ifdef GDM_BRAM_CLEAR_EN
      if (m_busy) begin
        exp_wea   = 1;
        exp_addra = m_cnt[AW-1:0];
        exp_dina  = '0;
        if (m_cnt == int'(GDM_DEPTH) - 1) begin
          m_busy = 0; exp_done = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else if (clr_start) begin
        m_busy = 1;
        m_cnt  = 0;
      end
`endif
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    if (rst) begin
      chk("rst bram_wea", bram_wea, '0);
      chk("rst rd_rsp_valid", rd_rsp_valid, '0);
      chk("rst clr_busy", clr_busy, '0);
      chk("rst clr_done", clr_done, '0);
    end else begin
      g = exp_grant();
      chk("wr0_ready", wr0_ready, g[0]);
      chk("wr1_ready", wr1_ready, g[1]);
      chk("rd_req_ready", rd_req_ready, !m_busy);
      chk("bram_addrb", bram_addrb, rd_req_addr);
      chk("bram_wea", bram_wea, exp_wea);
      if (exp_wea) begin
        chk("bram_addra", bram_addra, exp_addra);
        chk("bram_dina", bram_dina, exp_dina);
      end
      chk("rd_rsp_valid", rd_rsp_valid, exp_rsp_valid);
      if (exp_rsp_valid) chk("rd_rsp_data", rd_rsp_data, exp_rsp_data);
      chk("clr_busy", clr_busy, m_busy);
      chk("clr_done", clr_done, exp_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr0_valid = 1'b1; wr0_addr = a; wr0_data = d;
    step();
    wr0_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_req_valid = 1'b1; rd_req_addr = a;
    step();
    rd_req_valid = 1'b0;
    chk({name, " valid"}, rd_rsp_valid, 1);
    chk(name, rd_rsp_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    exp_g [4];
    logic [AW-1:0] rd_a  [4];
    logic [DW-1:0] rd_d  [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    step(); step(); step();
    chk("reset bram_addra", bram_addra, '0);
    chk("reset bram_dina", bram_dina, '0);
    rst = 1'b0;
    step();

    // Single write then read-back.
    wr0_valid = 1'b1; wr0_addr = 10'd5; wr0_data = 75'h123;
    #1 chk("t1 wr0_ready", wr0_ready, 1);
    step();
    wr0_valid = 1'b0;
    chk("t1 bram_wea", bram_wea, 1);
    chk("t1 bram_addra", bram_addra, 10'd5);
    chk("t1 bram_dina", bram_dina, 75'h123);
    read_chk("t1 read 5", 10'd5, 75'h123);

    // Contention right after reset alternates 0,1,0,1.
    reset_dut();
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr0_addr = 10'(20 + i); wr0_data = 75'(32'h100 + 20 + i);
      wr1_addr = 10'(40 + i); wr1_data = 75'(32'h100 + 40 + i);
      #1 chk("rr grant", {wr1_ready, wr0_ready}, exp_g[i]);
      step();
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    chk("rr last wea", bram_wea, 1);
    step();
    rd_a = '{10'd20, 10'd41, 10'd22, 10'd43};
    rd_d = '{75'h114, 75'h129, 75'h116, 75'h12B};
    rd_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_req_addr = rd_a[i];
      step();
      chk("b2b rsp valid", rd_rsp_valid, 1);
      chk("b2b rsp data", rd_rsp_data, rd_d[i]);
    end
    rd_req_valid = 1'b0;

    // Same-cycle write/read returns old data, next cycle returns new.
    reset_dut();
    write0(10'd10, 75'h55);
    step();
    wr0_valid = 1'b1; wr0_addr = 10'd10; wr0_data = 75'h7;
    rd_req_valid = 1'b1; rd_req_addr = 10'd10;
    step();
    wr0_valid = 1'b0;
    chk("order old data", rd_rsp_data, 75'h55);
    step();
    rd_req_valid = 1'b0;
    chk("order new data", rd_rsp_data, 75'h7);
    step();

`ifdef GDM_BRAM_CLEAR_EN
    begin
      int c;
      int busy_cnt;
      reset_dut();
      write0(10'd0, 75'hAAA);
      write0(10'd512, 75'hBBB);
      write0(10'd1023, 75'hCCC);
      step();
      clr_start = 1'b1;
      wr1_valid = 1'b1; wr1_addr = 10'd700; wr1_data = 75'hDDD;
      #1 chk("clr concurrent wr1_ready", wr1_ready, 1);
      step();
      clr_start = 1'b0; wr1_valid = 1'b0;
      wr0_valid = 1'b1; wr0_addr = 10'd100; wr0_data = 75'h9;
      chk("clr granted write first addr", bram_addra, 10'd700);
      chk("clr busy start", clr_busy, 1);
      c = 0; busy_cnt = 0;
      while (c < 1100) begin
        if (clr_done) break;
        if (clr_busy) busy_cnt++;
        clr_start = (c == 10);
        step();
        c++;
      end
      clr_start = 1'b0;
      chk("clr_done seen", clr_done, 1);
      chk("clr busy cycles", 75'(busy_cnt), 75'd1024);
      chk("pending wr0 granted after sweep", wr0_ready, 1);
      step();
      wr0_valid = 1'b0;
      step();
      read_chk("swept 0", 10'd0, 75'h0);
      read_chk("swept 512", 10'd512, 75'h0);
      read_chk("swept 1023", 10'd1023, 75'h0);
      read_chk("swept 700", 10'd700, 75'h0);
      read_chk("post-sweep 100", 10'd100, 75'h9);

      // Reset part-way through a sweep aborts it.
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (300) step();
      rst = 1'b1;
      #1 chk("abort busy drops", clr_busy, 0);
      chk("abort wea drops", bram_wea, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
        chk("abort no done", clr_done, 0);
        step();
      end
      write0(10'd7, 75'h3A);
      read_chk("abort traffic", 10'd7, 75'h3A);
    end
`else
    reset_dut();
    clr_start = 1'b1;
    wr0_valid = 1'b1; wr0_addr = 10'd20; wr0_data = 75'h44;
    #1 chk("noclr wr0_ready", wr0_ready, 1);
    step();
    clr_start = 1'b0; wr0_valid = 1'b0;
    chk("noclr wea", bram_wea, 1);
    chk("noclr addra", bram_addra, 10'd20);
    chk("noclr busy", clr_busy, 0);
    read_chk("noclr read", 10'd20, 75'h44);
    chk("noclr done", clr_done, 0);
    step();
    chk("noclr busy later", clr_busy, 0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
